// File: rtl/cp0_ctrl.sv
// MIPS-style coprocessor-0 control block: Count/Compare timer, Status/Cause/EPC,
// exception entry and eret redirect, with combinational mfc0 read port.
module cp0_ctrl #(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
    parameter logic [31:0] EXC_VEC    = 32'hbfc0_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic [HW_INT_NUM-1:0] hw_int,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret,
    output logic                  int_req,
    output logic                  flush,
    output logic [31:0]           target_pc,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic [3:0]            r_presc;
    logic [7:0]            r_im;
    logic                  r_exl;
    logic                  r_ie;
    logic                  r_bd;
    logic                  r_ti;
    logic [HW_INT_NUM-1:0] r_hw;
    logic [1:0]            r_ip_sw;
    logic [4:0]            r_exccode;
    logic [31:0]           r_epc;
    logic [31:0]           r_badvaddr;

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_tick;
    logic        w_match;
    logic        w_exc_first;
    logic        w_exc_addr;
    logic [5:0]  w_hw6;
    logic [7:0]  w_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    assign w_wr_count   = we & (waddr == 5'd9);
    assign w_wr_compare = we & (waddr == 5'd11);
    assign w_wr_status  = we & (waddr == 5'd12);
    assign w_wr_cause   = we & (waddr == 5'd13);
    assign w_wr_epc     = we & (waddr == 5'd14);
    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_match      = (r_count == r_compare) && (r_compare != 32'd0);
    // EPC/BD are only captured for an exception taken outside exception level
    assign w_exc_first  = exc_valid & ~r_exl;
    assign w_exc_addr   = exc_valid & ((exc_code == 5'd4) | (exc_code == 5'd5));

    for (genvar g = 0; g < 6; g++) begin : g_hw
        if (g < HW_INT_NUM) begin : g_line
            assign w_hw6[g] = r_hw[g];
        end else begin : g_none
            assign w_hw6[g] = 1'b0;
        end
    end

    // IP[7] is shared between the timer and the sixth hardware line
    assign w_ip     = {w_hw6[5] | r_ti, w_hw6[4:0], r_ip_sw};
    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'd0};

    // Count register and its prescaler
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 32'd0;
            r_presc <= 4'd0;
        end else if (w_wr_count) begin
            r_count <= wdata;
            r_presc <= 4'd0;
        end else if (w_tick) begin
            r_count <= r_count + 32'd1;
            r_presc <= 4'd0;
        end else begin
            r_presc <= r_presc + 4'd1;
        end
    end

    // Compare register and the sticky timer interrupt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare <= wdata;
            r_ti      <= 1'b0;
        end else if (w_match) begin
            r_ti      <= 1'b1;
        end
    end

    // Status fields: exception beats eret beats mtc0 on EXL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_im  <= 8'd0;
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
        end else begin
            if (w_wr_status) begin
                r_im <= wdata[15:8];
                r_ie <= wdata[0];
            end
            if (exc_valid) begin
                r_exl <= 1'b1;
            end else if (eret) begin
                r_exl <= 1'b0;
            end else if (w_wr_status) begin
                r_exl <= wdata[1];
            end
        end
    end

    // Cause fields and hardware interrupt sampling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hw      <= '0;
            r_ip_sw   <= 2'd0;
            r_exccode <= 5'd0;
            r_bd      <= 1'b0;
        end else begin
            r_hw <= hw_int;
            if (w_wr_cause) begin
                r_ip_sw <= wdata[9:8];
            end
            if (exc_valid) begin
                r_exccode <= exc_code;
            end
            if (w_exc_first) begin
                r_bd <= exc_bd;
            end
        end
    end

    // EPC and BadVAddr capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
        end else begin
            if (w_exc_first) begin
                r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            end else if (w_wr_epc) begin
                r_epc <= wdata;
            end
            if (w_exc_addr) begin
                r_badvaddr <= exc_badvaddr;
            end
        end
    end

    // mfc0 read mux, pre-write view
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            5'd8:    rdata = r_badvaddr;
            5'd9:    rdata = r_count;
            5'd11:   rdata = r_compare;
            5'd12:   rdata = w_status;
            5'd13:   rdata = w_cause;
            5'd14:   rdata = r_epc;
            5'd15:   rdata = PRID_VAL;
            5'd16:   rdata = 32'h0000_8000;
            default: rdata = 32'd0;
        endcase
    end

    // Redirect target for exception entry or eret
    always_comb begin
        target_pc = 32'd0;
        if (exc_valid) begin
            target_pc = EXC_VEC;
        end else if (eret) begin
            target_pc = w_wr_epc ? wdata : r_epc;
        end else begin
            target_pc = 32'd0;
        end
    end

    assign flush    = exc_valid | eret;
    assign int_req  = r_ie & ~r_exl & (|(r_im & w_ip));
    assign status_o = w_status;
    assign cause_o  = w_cause;
    assign epc_o    = r_epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed scenarios plus randomized traffic checked
// against a register-level reference model.
module tb_cp0_ctrl;

    localparam int          HW_INT_NUM = 6;
    localparam int          COUNT_DIV  = 2;
    localparam logic [31:0] PRID_VAL   = 32'h004c_0102;
    localparam logic [31:0] EXC_VEC    = 32'hbfc0_0380;

    logic                  clk;
    logic                  rst;
    logic                  we;
    logic [4:0]            waddr;
    logic [31:0]           wdata;
    logic [4:0]            raddr;
    logic [31:0]           rdata;
    logic [HW_INT_NUM-1:0] hw_int;
    logic                  exc_valid;
    logic [4:0]            exc_code;
    logic [31:0]           exc_pc;
    logic                  exc_bd;
    logic [31:0]           exc_badvaddr;
    logic                  eret;
    logic                  int_req;
    logic                  flush;
    logic [31:0]           target_pc;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic [31:0]           epc_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_count, m_compare, m_epc, m_badv;
    int          m_presc;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [5:0]  m_hw;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;

    cp0_ctrl #(
        .HW_INT_NUM(HW_INT_NUM),
        .COUNT_DIV (COUNT_DIV),
        .PRID_VAL  (PRID_VAL),
        .EXC_VEC   (EXC_VEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .hw_int      (hw_int),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .exc_bd      (exc_bd),
        .exc_badvaddr(exc_badvaddr),
        .eret        (eret),
        .int_req     (int_req),
        .flush       (flush),
        .target_pc   (target_pc),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
        exc_badvaddr = 32'd0; eret = 1'b0; hw_int = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] m_status_val();
        return 32'h0040_0000 | {16'h0000, m_im, 6'd0, m_exl, m_ie};
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_cause_val();
        return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'd0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status_val();
            5'd13:   return m_cause_val();
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            5'd16:   return 32'h0000_8000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_init();
        m_count = 32'd0; m_compare = 32'd0; m_epc = 32'd0; m_badv = 32'd0;
        m_presc = 0; m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
        m_ti = 1'b0; m_hw = 6'd0; m_ipsw = 2'd0; m_exc = 5'd0;
    endtask

    // advance the model by one clock edge using the inputs currently applied
    task automatic m_update();
        logic match_now;
        logic exl_before;
        match_now  = (m_count == m_compare) && (m_compare != 32'd0);
        exl_before = m_exl;
        if (we && waddr == 5'd9) begin
            m_count = wdata;
            m_presc = 0;
        end else if (m_presc == COUNT_DIV - 1) begin
            m_count = m_count + 32'd1;
            m_presc = 0;
        end else begin
            m_presc = m_presc + 1;
        end
        if (we && waddr == 5'd11) begin
            m_compare = wdata;
            m_ti      = 1'b0;
        end else if (match_now) begin
            m_ti = 1'b1;
        end
        m_hw = hw_int;
        if (we && waddr == 5'd12) begin
            m_im = wdata[15:8];
            m_ie = wdata[0];
        end
        if (exc_valid)                m_exl = 1'b1;
        else if (eret)                m_exl = 1'b0;
        else if (we && waddr == 5'd12) m_exl = wdata[1];
        if (we && waddr == 5'd13) m_ipsw = wdata[9:8];
        if (we && waddr == 5'd14) m_epc = wdata;
        if (exc_valid) begin
            m_exc = exc_code;
            if (!exl_before) begin
                m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                m_bd  = exc_bd;
            end
            if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badvaddr;
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        raddr = 5'd12;
        #2;
        total++; if (status_o !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0040_0000); end
        total++; if (cause_o !== 32'd0) begin bad++; $display("FAIL reset_cause got=%h exp=0", cause_o); end
        total++; if (epc_o !== 32'd0) begin bad++; $display("FAIL reset_epc got=%h exp=0", epc_o); end
        total++; if (int_req !== 1'b0 || flush !== 1'b0 || target_pc !== 32'd0) begin bad++; $display("FAIL reset_ctl int=%b flush=%b tpc=%h exp 0/0/0", int_req, flush, target_pc); end
        total++; if (rdata !== 32'h0040_0000) begin bad++; $display("FAIL reset_rd_status got=%h exp=%h", rdata, 32'h0040_0000); end
        raddr = 5'd15; #1;
        total++; if (rdata !== PRID_VAL) begin bad++; $display("FAIL rd_prid got=%h exp=%h", rdata, PRID_VAL); end
        raddr = 5'd16; #1;
        total++; if (rdata !== 32'h0000_8000) begin bad++; $display("FAIL rd_config got=%h exp=%h", rdata, 32'h0000_8000); end
    endtask

    task automatic test_count();
        do_reset();
        raddr = 5'd9;
        repeat (10) tick();
        total++; if (rdata !== 32'd5) begin bad++; $display("FAIL count_10cyc got=%0d exp=5", rdata); end
        we = 1'b1; waddr = 5'd9; wdata = 32'hffff_ffff;
        #1;
        total++; if (rdata !== 32'd5) begin bad++; $display("FAIL count_prewrite got=%h exp=5", rdata); end
        tick();
        idle();
        total++; if (rdata !== 32'hffff_ffff) begin bad++; $display("FAIL count_load got=%h exp=ffffffff", rdata); end
        tick(); tick();
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL count_wrap got=%h exp=0", rdata); end
    endtask

    task automatic test_timer();
        do_reset();
        we = 1'b1; waddr = 5'd11; wdata = 32'd3;
        tick();
        waddr = 5'd12; wdata = 32'h0000_8001;
        tick();
        idle();
        repeat (6) tick();
        total++; if (cause_o[30] !== 1'b1 || cause_o[15] !== 1'b1) begin bad++; $display("FAIL timer_ti got ti=%b ip7=%b exp 1/1", cause_o[30], cause_o[15]); end
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL timer_int got=%b exp=1", int_req); end
        we = 1'b1; waddr = 5'd11; wdata = 32'd100;
        tick();
        idle();
        total++; if (cause_o[30] !== 1'b0 || int_req !== 1'b0) begin bad++; $display("FAIL timer_clear got ti=%b int=%b exp 0/0", cause_o[30], int_req); end
        we = 1'b1; waddr = 5'd9; wdata = 32'd100;
        tick();
        waddr = 5'd11; wdata = 32'd200;
        tick();
        idle();
        total++; if (cause_o[30] !== 1'b0) begin bad++; $display("FAIL timer_match_vs_write got ti=%b exp=0", cause_o[30]); end
    endtask

    task automatic test_exception();
        do_reset();
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h8000_0010; exc_bd = 1'b1; exc_badvaddr = 32'h1;
        #1;
        total++; if (flush !== 1'b1 || target_pc !== EXC_VEC) begin bad++; $display("FAIL exc_redirect flush=%b tpc=%h exp 1/%h", flush, target_pc, EXC_VEC); end
        tick();
        idle();
        raddr = 5'd8;
        #1;
        total++; if (epc_o !== 32'h8000_000c) begin bad++; $display("FAIL exc_epc got=%h exp=8000000c", epc_o); end
        total++; if (cause_o[31] !== 1'b1 || status_o[1] !== 1'b1 || cause_o[6:2] !== 5'd4) begin bad++; $display("FAIL exc_fields bd=%b exl=%b code=%0d exp 1/1/4", cause_o[31], status_o[1], cause_o[6:2]); end
        total++; if (rdata !== 32'h1) begin bad++; $display("FAIL exc_badvaddr got=%h exp=1", rdata); end
        exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h9000_0000; exc_bd = 1'b0; exc_badvaddr = 32'h55;
        tick();
        idle();
        total++; if (epc_o !== 32'h8000_000c || cause_o[6:2] !== 5'd8) begin bad++; $display("FAIL exc2_nested epc=%h code=%0d exp 8000000c/8", epc_o, cause_o[6:2]); end
        total++; if (rdata !== 32'h1 || cause_o[31] !== 1'b1) begin bad++; $display("FAIL exc2_keep badv=%h bd=%b exp 1/1", rdata, cause_o[31]); end
    endtask

    task automatic test_eret();
        eret = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'h8000_0100;
        #1;
        total++; if (target_pc !== 32'h8000_0100 || flush !== 1'b1) begin bad++; $display("FAIL eret_bypass tpc=%h flush=%b exp 80000100/1", target_pc, flush); end
        tick();
        idle();
        total++; if (status_o[1] !== 1'b0 || epc_o !== 32'h8000_0100) begin bad++; $display("FAIL eret_after exl=%b epc=%h exp 0/80000100", status_o[1], epc_o); end
        exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_1234;
        tick();
        idle();
        eret = 1'b1; exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h0000_5678;
        #1;
        total++; if (target_pc !== EXC_VEC) begin bad++; $display("FAIL eret_exc_tpc got=%h exp=%h", target_pc, EXC_VEC); end
        tick();
        idle();
        total++; if (status_o[1] !== 1'b1 || epc_o !== 32'h0000_1234 || cause_o[6:2] !== 5'd12) begin bad++; $display("FAIL eret_exc_state exl=%b epc=%h code=%0d exp 1/1234/12", status_o[1], epc_o, cause_o[6:2]); end
    endtask

    task automatic test_interrupt_reset();
        do_reset();
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0401;
        tick();
        idle();
        hw_int = 6'b000001;
        #1;
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL hwint_early got=%b exp=0", int_req); end
        tick();
        total++; if (int_req !== 1'b1 || cause_o[10] !== 1'b1) begin bad++; $display("FAIL hwint_req int=%b ip2=%b exp 1/1", int_req, cause_o[10]); end
        raddr = 5'd9;
        #2;
        rst = 1'b0;
        #1;
        total++; if (int_req !== 1'b0 || status_o !== 32'h0040_0000 || cause_o !== 32'd0) begin bad++; $display("FAIL async_reset int=%b st=%h cause=%h exp 0/00400000/0", int_req, status_o, cause_o); end
        total++; if (rdata !== 32'd0 || epc_o !== 32'd0) begin bad++; $display("FAIL async_reset_rd count=%h epc=%h exp 0/0", rdata, epc_o); end
        idle();
    endtask

    task automatic test_random();
        int pick;
        do_reset();
        m_init();
        for (int cyc = 0; cyc < 600; cyc++) begin
            we = ($urandom_range(0, 1) == 1);
            pick = $urandom_range(0, 9);
            case (pick)
                0:       waddr = 5'd8;
                1:       waddr = 5'd9;
                2:       waddr = 5'd11;
                3:       waddr = 5'd12;
                4:       waddr = 5'd13;
                5:       waddr = 5'd14;
                6:       waddr = 5'd15;
                7:       waddr = 5'd16;
                default: waddr = 5'($urandom_range(0, 31));
            endcase
            wdata = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + 32'($urandom_range(0, 4));
            if (waddr == 5'd9 && $urandom_range(0, 1) == 1)  wdata = 32'hffff_fff0 + 32'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(8 + $urandom_range(0, 8));
            hw_int = 6'($urandom);
            exc_valid = ($urandom_range(0, 9) == 0);
            eret = ($urandom_range(0, 9) == 0);
            pick = $urandom_range(0, 2);
            exc_code = (pick == 0) ? 5'd4 : (pick == 1) ? 5'd5 : 5'($urandom_range(0, 31));
            exc_pc = $urandom;
            exc_bd = ($urandom_range(0, 1) == 1);
            exc_badvaddr = $urandom;
            if (exc_valid) we = 1'b0;
            #2;
            total++; if (rdata !== m_read(raddr)) begin bad++; $display("FAIL rnd_rdata cyc=%0d raddr=%0d got=%h exp=%h", cyc, raddr, rdata, m_read(raddr)); end
            total++; if (status_o !== m_status_val()) begin bad++; $display("FAIL rnd_status cyc=%0d got=%h exp=%h", cyc, status_o, m_status_val()); end
            total++; if (cause_o !== m_cause_val()) begin bad++; $display("FAIL rnd_cause cyc=%0d got=%h exp=%h", cyc, cause_o, m_cause_val()); end
            total++; if (epc_o !== m_epc) begin bad++; $display("FAIL rnd_epc cyc=%0d got=%h exp=%h", cyc, epc_o, m_epc); end
            total++; if (int_req !== (m_ie & ~m_exl & (|(m_im & m_ip())))) begin bad++; $display("FAIL rnd_int cyc=%0d got=%b exp=%b", cyc, int_req, m_ie & ~m_exl & (|(m_im & m_ip()))); end
            total++; if (flush !== (exc_valid | eret)) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", cyc, flush, exc_valid | eret); end
            total++; if (target_pc !== (exc_valid ? EXC_VEC : eret ? ((we && waddr == 5'd14) ? wdata : m_epc) : 32'd0)) begin
                bad++; $display("FAIL rnd_tpc cyc=%0d got=%h exp=%h", cyc, target_pc, exc_valid ? EXC_VEC : eret ? ((we && waddr == 5'd14) ? wdata : m_epc) : 32'd0);
            end
            @(posedge clk);
            m_update();
            #1;
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        raddr = 5'd0;
        idle();
        test_reset();
        test_count();
        test_timer();
        test_exception();
        test_eret();
        test_interrupt_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
